// File: rtl/biriscv_muldiv_pkg.sv
// Shared types for the mul/div issue scheduler: FSM encoding, default multiplier
// latency and the in-flight tracker entry layout.
package biriscv_muldiv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DIV_BUSY = 2'd1,
        ST_DIV_KILL = 2'd2
    } state_t;

    localparam int MUL_LATENCY_DEF = 2;
    localparam int RD_W            = 5;

    typedef struct packed {
        logic            vld;
        logic [RD_W-1:0] rd;
        logic            lane;
        logic            mulf;
    } trk_entry_t;

endpackage

// File: rtl/biriscv_muldiv_sched_if.sv
// Issue-stage <-> mul/div scheduler bundle: lane classification in, stalls,
// unit strobes and registered writeback out; no backpressure beyond the stalls.
interface biriscv_muldiv_sched_if;
    import biriscv_muldiv_pkg::*;

    logic            enable_muldiv_i;
    logic            flush_i;
    logic            lane0_valid_i;
    logic            lane0_mul_i;
    logic            lane0_div_i;
    logic            lane0_mulf_i;
    logic [RD_W-1:0] lane0_rd_idx_i;
    logic            lane1_valid_i;
    logic            lane1_mul_i;
    logic            lane1_div_i;
    logic            lane1_mulf_i;
    logic [RD_W-1:0] lane1_rd_idx_i;
    logic            lane0_stall_o;
    logic            lane1_stall_o;
    logic            unit_mul_valid_o;
    logic            unit_mulf_valid_o;
    logic            unit_div_valid_o;
    logic            unit_lane_o;
    logic            div_complete_i;
    logic            wb_valid_o;
    logic [RD_W-1:0] wb_rd_o;
    logic            wb_lane_o;
    logic            wb_div_o;
    logic            wb_mulf_o;
    logic            busy_o;

    modport master (
        output enable_muldiv_i, flush_i,
        output lane0_valid_i, lane0_mul_i, lane0_div_i, lane0_mulf_i, lane0_rd_idx_i,
        output lane1_valid_i, lane1_mul_i, lane1_div_i, lane1_mulf_i, lane1_rd_idx_i,
        output div_complete_i,
        input  lane0_stall_o, lane1_stall_o,
        input  unit_mul_valid_o, unit_mulf_valid_o, unit_div_valid_o, unit_lane_o,
        input  wb_valid_o, wb_rd_o, wb_lane_o, wb_div_o, wb_mulf_o, busy_o
    );

    modport slave (
        input  enable_muldiv_i, flush_i,
        input  lane0_valid_i, lane0_mul_i, lane0_div_i, lane0_mulf_i, lane0_rd_idx_i,
        input  lane1_valid_i, lane1_mul_i, lane1_div_i, lane1_mulf_i, lane1_rd_idx_i,
        input  div_complete_i,
        output lane0_stall_o, lane1_stall_o,
        output unit_mul_valid_o, unit_mulf_valid_o, unit_div_valid_o, unit_lane_o,
        output wb_valid_o, wb_rd_o, wb_lane_o, wb_div_o, wb_mulf_o, busy_o
    );

endinterface

// File: rtl/biriscv_muldiv_track.sv
// Multiplier in-flight tracker: DEPTH-stage shift register, entry reaches the last
// stage DEPTH cycles after load; no backpressure, flush drops every valid bit.
module biriscv_muldiv_track
    import biriscv_muldiv_pkg::*;
#(
    parameter int DEPTH = MUL_LATENCY_DEF
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       flush_i,
    input  logic       load_i,
    input  trk_entry_t load_entry_i,
    output trk_entry_t head_nxt_o,
    output logic       any_vld_o
);

    trk_entry_t [DEPTH-1:0] stage_q;
    trk_entry_t [DEPTH-1:0] stage_nxt;

    always_comb begin
        stage_nxt        = '0;
        stage_nxt[0]     = load_entry_i;
        stage_nxt[0].vld = load_i;
        for (int i = 1; i < DEPTH; i++) begin
            stage_nxt[i] = stage_q[i-1];
        end
        if (flush_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_nxt[i].vld = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_nxt;
        end
    end

    // The entry about to land in the last stage feeds the writeback registers, so
    // the writeback strobe lines up with the last stage's valid bit.
    assign head_nxt_o = stage_nxt[DEPTH-1];

    always_comb begin
        any_vld_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            any_vld_o = any_vld_o | stage_q[i].vld;
        end
    end

endmodule

// File: rtl/biriscv_muldiv_sched.sv
// Mul/div issue scheduler: 0-cycle issue/stall decision, writeback registered
// (MUL_LATENCY after mul issue, 1 after div_complete); lanes stall when unit unavailable.
module biriscv_muldiv_sched
    import biriscv_muldiv_pkg::*;
#(
    parameter int MUL_LATENCY = MUL_LATENCY_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    biriscv_muldiv_sched_if.slave bus
);

    state_t          state_q;
    state_t          state_nxt;
    logic            req0;
    logic            req1;
    logic            can0;
    logic            can1;
    logic            issue0;
    logic            issue1;
    logic            stall0;
    logic            stall1;
    logic            unit_mul;
    logic            unit_mulf;
    logic            unit_div;
    logic            trk_any;
    trk_entry_t      load_entry;
    trk_entry_t      head_nxt;
    logic [RD_W-1:0] div_rd_q;
    logic            div_lane_q;
    logic            div_done;

    logic            wb_valid_q;
    logic [RD_W-1:0] wb_rd_q;
    logic            wb_lane_q;
    logic            wb_div_q;
    logic            wb_mulf_q;
    logic            wb_valid_nxt;
    logic [RD_W-1:0] wb_rd_nxt;
    logic            wb_lane_nxt;
    logic            wb_div_nxt;
    logic            wb_mulf_nxt;

    // Divides also wait for the mul tracker to drain so the two writeback
    // sources can never land in the same cycle.
    always_comb begin
        req0   = bus.lane0_valid_i & (bus.lane0_mul_i | bus.lane0_div_i | bus.lane0_mulf_i)
                 & bus.enable_muldiv_i & ~bus.flush_i;
        req1   = bus.lane1_valid_i & (bus.lane1_mul_i | bus.lane1_div_i | bus.lane1_mulf_i)
                 & bus.enable_muldiv_i & ~bus.flush_i;
        can0   = (state_q == ST_IDLE) & ~(bus.lane0_div_i & trk_any);
        can1   = (state_q == ST_IDLE) & ~(bus.lane1_div_i & trk_any);
        stall0 = req0 & ~can0;
        issue0 = req0 & can0;
        stall1 = stall0 | (req1 & (issue0 | ~can1));
        issue1 = req1 & ~stall1;
    end

    assign unit_mul  = (issue0 & bus.lane0_mul_i)  | (issue1 & bus.lane1_mul_i);
    assign unit_mulf = (issue0 & bus.lane0_mulf_i) | (issue1 & bus.lane1_mulf_i);
    assign unit_div  = (issue0 & bus.lane0_div_i)  | (issue1 & bus.lane1_div_i);

    assign bus.lane0_stall_o     = stall0;
    assign bus.lane1_stall_o     = stall1;
    assign bus.unit_mul_valid_o  = unit_mul;
    assign bus.unit_mulf_valid_o = unit_mulf;
    assign bus.unit_div_valid_o  = unit_div;
    assign bus.unit_lane_o       = issue1;

    always_comb begin
        load_entry      = '0;
        load_entry.vld  = unit_mul | unit_mulf;
        load_entry.rd   = issue1 ? bus.lane1_rd_idx_i : bus.lane0_rd_idx_i;
        load_entry.lane = issue1;
        load_entry.mulf = unit_mulf;
    end

    biriscv_muldiv_track #(
        .DEPTH (MUL_LATENCY)
    ) u_track (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .flush_i      (bus.flush_i),
        .load_i       (load_entry.vld),
        .load_entry_i (load_entry),
        .head_nxt_o   (head_nxt),
        .any_vld_o    (trk_any)
    );

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE: begin
                if (unit_div) begin
                    state_nxt = ST_DIV_BUSY;
                end
            end
            ST_DIV_BUSY: begin
                if (bus.div_complete_i) begin
                    state_nxt = ST_IDLE;
                end else if (bus.flush_i) begin
                    state_nxt = ST_DIV_KILL;
                end
            end
            ST_DIV_KILL: begin
                if (bus.div_complete_i) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            div_rd_q   <= '0;
            div_lane_q <= 1'b0;
        end else begin
            state_q <= state_nxt;
            if (unit_div) begin
                div_rd_q   <= issue1 ? bus.lane1_rd_idx_i : bus.lane0_rd_idx_i;
                div_lane_q <= issue1;
            end
        end
    end

    // A flush in the completion cycle discards the divide result.
    assign div_done = (state_q == ST_DIV_BUSY) & bus.div_complete_i & ~bus.flush_i;

    always_comb begin
        wb_valid_nxt = 1'b0;
        wb_rd_nxt    = '0;
        wb_lane_nxt  = 1'b0;
        wb_div_nxt   = 1'b0;
        wb_mulf_nxt  = 1'b0;
        if (head_nxt.vld) begin
            wb_valid_nxt = 1'b1;
            wb_rd_nxt    = head_nxt.rd;
            wb_lane_nxt  = head_nxt.lane;
            wb_mulf_nxt  = head_nxt.mulf;
        end else if (div_done) begin
            wb_valid_nxt = 1'b1;
            wb_rd_nxt    = div_rd_q;
            wb_lane_nxt  = div_lane_q;
            wb_div_nxt   = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_lane_q  <= 1'b0;
            wb_div_q   <= 1'b0;
            wb_mulf_q  <= 1'b0;
        end else begin
            wb_valid_q <= wb_valid_nxt;
            wb_rd_q    <= wb_rd_nxt;
            wb_lane_q  <= wb_lane_nxt;
            wb_div_q   <= wb_div_nxt;
            wb_mulf_q  <= wb_mulf_nxt;
        end
    end

    assign bus.wb_valid_o = wb_valid_q;
    assign bus.wb_rd_o    = wb_rd_q;
    assign bus.wb_lane_o  = wb_lane_q;
    assign bus.wb_div_o   = wb_div_q;
    assign bus.wb_mulf_o  = wb_mulf_q;
    assign bus.busy_o     = (state_q != ST_IDLE) | trk_any;

endmodule
